accel_hub: RTL and testbench



---
 rtl/accel_hub_if.sv | 25 ++
 rtl/accel_hub.sv | 147 ++++++++++++++
 tb/tb_accel_hub.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/accel_hub_if.sv
// CPU-side accelerator port bundle.
//   master : CPU side, drives channel id, read/write strobes and write data
//   slave  : hub side, returns can_read/can_write and read data
interface accel_hub_if #(
   parameter int ID_WIDTH   = 4,
   parameter int DATA_WIDTH = 16
);
   logic [ID_WIDTH-1:0]   accel_id;
   logic                  accel_can_read;
   logic                  accel_can_write;
   logic                  accel_read_enable;
   logic                  accel_write_enable;
   logic [DATA_WIDTH-1:0] accel_read_data;
   logic [DATA_WIDTH-1:0] accel_write_data;

   modport master (
      output accel_id, accel_read_enable, accel_write_enable, accel_write_data,
      input  accel_can_read, accel_can_write, accel_read_data
   );

   modport slave (
      input  accel_id, accel_read_enable, accel_write_enable, accel_write_data,
      output accel_can_read, accel_can_write, accel_read_data
   );
endinterface

// File: rtl/accel_hub.sv
// Accelerator interconnect between the CPU accelerator port and NUM_ACCELS
// device adapters.
//   clk, rst_n        : clock, async active-low reset
//   cpu_rst           : CPU reset, released on the first edge after rst_n rises
//   cpu (slave)       : CPU accelerator port (id, strobes, data, can_read/can_write)
//   dev_can_read/write: per-device ready flags
//   dev_read_enable   : per-device read strobe (combinational pass-through)
//   dev_write_enable  : per-device write strobe from the posted-write FIFO head
//   dev_read_data     : packed device read data, device i at [i*DATA_WIDTH +: DATA_WIDTH]
//   dev_write_data    : data of the FIFO head entry
//   event_in          : per-channel event pulse (event channels only)
//   fifo_level        : posted-write FIFO occupancy
module accel_hub #(
   parameter int                    NUM_ACCELS = 4,
   parameter int                    DATA_WIDTH = 16,
   parameter int                    ID_WIDTH   = 4,
   parameter int                    FIFO_DEPTH = 4,
   parameter logic [NUM_ACCELS-1:0] EVENT_MASK = NUM_ACCELS'(1)
) (
   input  logic                             clk,
   input  logic                             rst_n,
   output logic                             cpu_rst,
   accel_hub_if.slave                       cpu,
   input  logic [NUM_ACCELS-1:0]            dev_can_read,
   input  logic [NUM_ACCELS-1:0]            dev_can_write,
   output logic [NUM_ACCELS-1:0]            dev_read_enable,
   output logic [NUM_ACCELS-1:0]            dev_write_enable,
   input  logic [NUM_ACCELS*DATA_WIDTH-1:0] dev_read_data,
   output logic [DATA_WIDTH-1:0]            dev_write_data,
   input  logic [NUM_ACCELS-1:0]            event_in,
   output logic [$clog2(FIFO_DEPTH):0]      fifo_level
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam int ENT_W = ID_WIDTH + DATA_WIDTH;

   logic                  cpu_rst_q, cpu_rst_d;
   logic [NUM_ACCELS-1:0] pending_q, pending_d;
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]      level_q, level_d;
   logic [ENT_W-1:0]      mem_q [FIFO_DEPTH];
   logic [ENT_W-1:0]      mem_d [FIFO_DEPTH];

   logic [NUM_ACCELS-1:0] sel;
   logic [NUM_ACCELS-1:0] head_sel;
   logic [ID_WIDTH-1:0]   head_id;
   logic                  fifo_empty;
   logic                  is_normal;
   logic                  can_read;
   logic                  can_write;
   logic                  read_done;
   logic                  push;
   logic                  pop;

   assign fifo_empty = (level_q == '0);
   assign head_id    = mem_q[rd_ptr_q][ENT_W-1 -: ID_WIDTH];

   // One-hot decode of the CPU id and the FIFO head id; ids at or above
   // NUM_ACCELS decode to all-zero and so select nothing.
   always_comb begin
      sel      = '0;
      head_sel = '0;
      for (int i = 0; i < NUM_ACCELS; i++) begin
         sel[i]      = (cpu.accel_id == ID_WIDTH'(i));
         head_sel[i] = (head_id == ID_WIDTH'(i));
      end
   end

   assign is_normal = |(sel & ~EVENT_MASK);

   // Normal reads wait for an empty FIFO so a read never overtakes posted writes.
   assign can_read  = (|(sel & EVENT_MASK & pending_q))
                    | ((|(sel & ~EVENT_MASK & dev_can_read)) & fifo_empty);
   // Registered level only: a pop on this edge does not free a slot for this push.
   assign can_write = is_normal & (level_q < LVL_W'(FIFO_DEPTH));
   assign read_done = cpu.accel_read_enable & can_read;
   assign push      = cpu.accel_write_enable & can_write;

   assign dev_read_enable  = read_done ? (sel & ~EVENT_MASK) : '0;
   assign dev_write_enable = fifo_empty ? '0 : (head_sel & dev_can_write & ~EVENT_MASK);
   assign pop              = |dev_write_enable;
   assign dev_write_data   = mem_q[rd_ptr_q][DATA_WIDTH-1:0];

   assign cpu.accel_can_read  = can_read;
   assign cpu.accel_can_write = can_write;
   assign cpu_rst             = cpu_rst_q;
   assign fifo_level          = level_q;

   always_comb begin
      cpu.accel_read_data = '0;
      for (int i = 0; i < NUM_ACCELS; i++) begin
         if (sel[i] && !EVENT_MASK[i]) begin
            cpu.accel_read_data = dev_read_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_comb begin
      cpu_rst_d = 1'b0;

      // Event set has priority over a same-cycle read clear.
      pending_d = pending_q;
      for (int i = 0; i < NUM_ACCELS; i++) begin
         if (event_in[i]) begin
            pending_d[i] = 1'b1;
         end else if (read_done && sel[i]) begin
            pending_d[i] = 1'b0;
         end
      end
      pending_d = pending_d & EVENT_MASK;

      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) begin
         mem_d[wr_ptr_q] = {cpu.accel_id, cpu.accel_write_data};
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      level_d = level_q + LVL_W'(push) - LVL_W'(pop);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cpu_rst_q <= 1'b1;
         pending_q <= EVENT_MASK;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         level_q   <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         cpu_rst_q <= cpu_rst_d;
         pending_q <= pending_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         level_q   <= level_d;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
      end
   end
endmodule

// File: tb/tb_accel_hub.sv
// Self-checking bench for accel_hub: constant vector table, directed
// multi-cycle sequences and a randomized phase, all checked against a
// queue-based reference model.
module tb_accel_hub;
   localparam int N  = 4;
   localparam int DW = 16;
   localparam int IW = 4;
   localparam int FD = 4;
   localparam logic [N-1:0] EMASK = 4'b0001;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            cpu_rst;
   logic [N-1:0]    dev_can_read, dev_can_write, dev_read_enable, dev_write_enable, event_in;
   logic [N*DW-1:0] dev_read_data;
   logic [DW-1:0]   dev_write_data;
   logic [2:0]      fifo_level;

   accel_hub_if #(.ID_WIDTH(IW), .DATA_WIDTH(DW)) cpu_if ();

   accel_hub #(
      .NUM_ACCELS(N), .DATA_WIDTH(DW), .ID_WIDTH(IW), .FIFO_DEPTH(FD), .EVENT_MASK(EMASK)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .cpu_rst          (cpu_rst),
      .cpu              (cpu_if),
      .dev_can_read     (dev_can_read),
      .dev_can_write    (dev_can_write),
      .dev_read_enable  (dev_read_enable),
      .dev_write_enable (dev_write_enable),
      .dev_read_data    (dev_read_data),
      .dev_write_data   (dev_write_data),
      .event_in         (event_in),
      .fifo_level       (fifo_level)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [IW-1:0] id;
      logic [DW-1:0] data;
   } ent_t;

   ent_t          m_q[$];
   logic [N-1:0]  m_pend;
   logic          m_cpu_rst;
   logic          m_push, m_pop, m_rdone;
   int            m_id;
   int            seen_id[$];
   logic [DW-1:0] seen_data[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_pend    = EMASK;
      m_cpu_rst = 1'b1;
   endtask

   // Expected outputs from the current model state and driven inputs.
   task automatic model_check();
      int            id;
      logic          e_cr, e_cw;
      logic [DW-1:0] e_rd;
      logic [N-1:0]  e_dre, e_dwe;
      id    = int'(cpu_if.accel_id);
      e_cr  = 1'b0;
      e_cw  = 1'b0;
      e_rd  = '0;
      e_dre = '0;
      e_dwe = '0;
      if (id < N) begin
         if (EMASK[id]) begin
            e_cr = m_pend[id];
         end else begin
            e_cr = dev_can_read[id] && (m_q.size() == 0);
            e_cw = (m_q.size() < FD);
            e_rd = dev_read_data[id*DW +: DW];
            if (cpu_if.accel_read_enable && e_cr) e_dre[id] = 1'b1;
         end
      end
      if (m_q.size() > 0 && dev_can_write[m_q[0].id]) e_dwe[m_q[0].id] = 1'b1;

      chk("cpu_rst", 64'(cpu_rst), 64'(m_cpu_rst));
      chk("can_read", 64'(cpu_if.accel_can_read), 64'(e_cr));
      chk("can_write", 64'(cpu_if.accel_can_write), 64'(e_cw));
      chk("read_data", 64'(cpu_if.accel_read_data), 64'(e_rd));
      chk("dev_read_enable", 64'(dev_read_enable), 64'(e_dre));
      chk("dev_write_enable", 64'(dev_write_enable), 64'(e_dwe));
      chk("fifo_level", 64'(fifo_level), 64'(m_q.size()));
      if (m_q.size() > 0) chk("dev_write_data", 64'(dev_write_data), 64'(m_q[0].data));

      for (int i = 0; i < N; i++) begin
         if (dev_write_enable[i]) begin
            seen_id.push_back(i);
            seen_data.push_back(dev_write_data);
         end
      end

      m_push  = cpu_if.accel_write_enable && e_cw;
      m_pop   = (e_dwe != '0);
      m_rdone = cpu_if.accel_read_enable && e_cr;
      m_id    = id;
   endtask

   // Inputs are driven at posedge+1; check at posedge+2, commit at the edge.
   task automatic cycle();
      ent_t e;
      #1;
      model_check();
      e.id   = cpu_if.accel_id;
      e.data = cpu_if.accel_write_data;
      @(posedge clk);
      if (m_pop) void'(m_q.pop_front());
      if (m_push) m_q.push_back(e);
      for (int i = 0; i < N; i++) begin
         if (EMASK[i]) begin
            if (event_in[i]) m_pend[i] = 1'b1;
            else if (m_rdone && m_id == i) m_pend[i] = 1'b0;
         end
      end
      m_cpu_rst = 1'b0;
      #1;
   endtask

   task automatic idle();
      cpu_if.accel_read_enable  = 1'b0;
      cpu_if.accel_write_enable = 1'b0;
      event_in                  = '0;
   endtask

   task automatic cpu_write(input logic [IW-1:0] id, input logic [DW-1:0] d);
      cpu_if.accel_id           = id;
      cpu_if.accel_write_data   = d;
      cpu_if.accel_write_enable = 1'b1;
      cycle();
      cpu_if.accel_write_enable = 1'b0;
   endtask

   typedef struct {
      logic [IW-1:0] id;
      logic          rd;
      logic [N-1:0]  dcr;
      logic          e_cr;
      logic          e_cw;
      logic [DW-1:0] e_rd;
      logic [N-1:0]  e_dre;
   } vec_t;

   vec_t vt[7];

   initial begin
      vt[0] = '{4'd0,  1'b0, 4'b0000, 1'b1, 1'b0, 16'h0000, 4'b0000};
      vt[1] = '{4'd1,  1'b1, 4'b0010, 1'b1, 1'b1, 16'hD001, 4'b0010};
      vt[2] = '{4'd2,  1'b1, 4'b1011, 1'b0, 1'b1, 16'hD002, 4'b0000};
      vt[3] = '{4'd3,  1'b1, 4'b1000, 1'b1, 1'b1, 16'hD003, 4'b1000};
      vt[4] = '{4'd4,  1'b1, 4'b1111, 1'b0, 1'b0, 16'h0000, 4'b0000};
      vt[5] = '{4'd15, 1'b1, 4'b1111, 1'b0, 1'b0, 16'h0000, 4'b0000};
      vt[6] = '{4'd0,  1'b0, 4'b1111, 1'b1, 1'b0, 16'h0000, 4'b0000};

      idle();
      cpu_if.accel_id         = '0;
      cpu_if.accel_write_data = '0;
      dev_can_read            = '0;
      dev_can_write           = '0;
      dev_read_data           = {16'hD003, 16'hD002, 16'hD001, 16'hD000};
      model_reset();

      // Reset held for 3 cycles.
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_cpu_rst", 64'(cpu_rst), 64'd1);
      chk("rst_level", 64'(fifo_level), 64'd0);
      chk("rst_dev_we", 64'(dev_write_enable), 64'd0);
      chk("rst_dev_re", 64'(dev_read_enable), 64'd0);
      chk("rst_dev_wdata", 64'(dev_write_data), 64'd0);
      chk("rst_pending_id0", 64'(cpu_if.accel_can_read), 64'd1);
      rst_n = 1'b1;
      cycle();
      chk("cpu_rst_released", 64'(cpu_rst), 64'd0);

      // Channel classification table (FIFO empty, pending[0]=1).
      for (int k = 0; k < 7; k++) begin
         cpu_if.accel_id          = vt[k].id;
         cpu_if.accel_read_enable = vt[k].rd;
         dev_can_read             = vt[k].dcr;
         #1;
         chk($sformatf("vec%0d_can_read", k), 64'(cpu_if.accel_can_read), 64'(vt[k].e_cr));
         chk($sformatf("vec%0d_can_write", k), 64'(cpu_if.accel_can_write), 64'(vt[k].e_cw));
         chk($sformatf("vec%0d_read_data", k), 64'(cpu_if.accel_read_data), 64'(vt[k].e_rd));
         chk($sformatf("vec%0d_dev_re", k), 64'(dev_read_enable), 64'(vt[k].e_dre));
         cycle();
      end
      idle();
      dev_can_read = '0;

      // Event set wins over a simultaneous read clear.
      cpu_if.accel_id          = 4'd0;
      cpu_if.accel_read_enable = 1'b1;
      event_in                 = 4'b0001;
      cycle();
      idle();
      #1;
      chk("event_set_wins", 64'(cpu_if.accel_can_read), 64'd1);
      cpu_if.accel_read_enable = 1'b1;
      cycle();
      idle();
      #1;
      chk("event_cleared", 64'(cpu_if.accel_can_read), 64'd0);

      // Posted writes held off by a busy device, then drained in order.
      dev_can_write = 4'b0000;
      cpu_write(4'd1, 16'h1111);
      cpu_write(4'd1, 16'h2222);
      cpu_write(4'd1, 16'h3333);
      #1;
      chk("posted_level3", 64'(fifo_level), 64'd3);
      dev_can_write = 4'b0010;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk($sformatf("drain%0d_we", k), 64'(dev_write_enable), 64'b0010);
         chk($sformatf("drain%0d_data", k), 64'(dev_write_data), 64'(16'h1111 * (k + 1)));
         cycle();
      end
      #1;
      chk("drain_level0", 64'(fifo_level), 64'd0);
      chk("drain_no_more_we", 64'(dev_write_enable), 64'd0);
      cycle();

      // Full FIFO: fifth write is dropped.
      dev_can_write = 4'b0000;
      for (int k = 0; k < 4; k++) cpu_write(4'd2, 16'h4000 + 16'(k));
      #1;
      chk("full_can_write", 64'(cpu_if.accel_can_write), 64'd0);
      cpu_write(4'd2, 16'h5555);
      #1;
      chk("full_level4", 64'(fifo_level), 64'd4);
      seen_id.delete();
      seen_data.delete();
      dev_can_write = 4'b1111;
      repeat (6) cycle();
      chk("full_drain_count", 64'(seen_data.size()), 64'd4);
      for (int k = 0; k < 4 && k < seen_data.size(); k++) begin
         chk($sformatf("full_drain%0d_data", k), 64'(seen_data[k]), 64'(16'h4000 + k));
      end

      // Head-of-line blocking and read-after-write ordering.
      dev_can_write = 4'b1000;
      cpu_write(4'd1, 16'hAAAA);
      cpu_write(4'd3, 16'hBBBB);
      cpu_if.accel_id          = 4'd3;
      cpu_if.accel_read_enable = 1'b1;
      dev_can_read             = 4'b1000;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk($sformatf("hol%0d_no_we", k), 64'(dev_write_enable), 64'd0);
         chk($sformatf("hol%0d_read_blocked", k), 64'(cpu_if.accel_can_read), 64'd0);
         cycle();
      end
      cpu_if.accel_read_enable = 1'b0;
      dev_can_write = 4'b1010;
      #1;
      chk("hol_first_we", 64'(dev_write_enable), 64'b0010);
      chk("hol_first_data", 64'(dev_write_data), 64'hAAAA);
      cycle();
      #1;
      chk("hol_second_we", 64'(dev_write_enable), 64'b1000);
      chk("hol_second_data", 64'(dev_write_data), 64'hBBBB);
      cycle();
      #1;
      chk("hol_read_unblocked", 64'(cpu_if.accel_can_read), 64'd1);
      dev_can_read = '0;

      // Invalid id with both strobes.
      cpu_if.accel_id           = 4'd4;
      cpu_if.accel_read_enable  = 1'b1;
      cpu_if.accel_write_enable = 1'b1;
      dev_can_read              = 4'b1111;
      #1;
      chk("inv_can_read", 64'(cpu_if.accel_can_read), 64'd0);
      chk("inv_can_write", 64'(cpu_if.accel_can_write), 64'd0);
      chk("inv_read_data", 64'(cpu_if.accel_read_data), 64'd0);
      chk("inv_dev_re", 64'(dev_read_enable), 64'd0);
      cycle();
      idle();
      #1;
      chk("inv_level", 64'(fifo_level), 64'd0);

      // Asynchronous reset mid-drain discards queued writes.
      dev_can_write = 4'b0000;
      cpu_write(4'd1, 16'hC001);
      cpu_write(4'd1, 16'hC002);
      cpu_write(4'd1, 16'hC003);
      dev_can_write = 4'b0010;
      cycle();
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_no_we", 64'(dev_write_enable), 64'd0);
      chk("mid_rst_level", 64'(fifo_level), 64'd0);
      chk("mid_rst_cpu_rst", 64'(cpu_rst), 64'd1);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      seen_id.delete();
      seen_data.delete();
      repeat (4) cycle();
      chk("mid_rst_no_strobes_after", 64'(seen_data.size()), 64'd0);

      // Randomized traffic against the model.
      for (int k = 0; k < 500; k++) begin
         cpu_if.accel_id           = IW'($urandom_range(0, 5));
         cpu_if.accel_read_enable  = ($urandom_range(0, 2) == 0);
         cpu_if.accel_write_enable = ($urandom_range(0, 1) == 0);
         cpu_if.accel_write_data   = DW'($urandom);
         dev_can_read              = N'($urandom);
         dev_can_write             = N'($urandom) & N'($urandom);
         dev_read_data             = {$urandom, $urandom};
         event_in                  = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
